// File: rtl/mul_fp_pipe_if.sv
// Operand/result handshake bundle for the pipelined floating-point multiplier.
// The multiplier uses the slave modport; the operand source/result sink uses master.
interface mul_fp_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = EXP_W + MAN_W + 1;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic [3:0]   flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out, flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out, flags
    );
endinterface

// File: rtl/mul_fp_pipe.sv
// Three-stage IEEE-754-style multiplier: unpack/classify, mantissa product, normalise/round/pack.
// Optional MUL_FP_ROUND_EN selects round-to-nearest-even; without it the mantissa is truncated.
module mul_fp_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic          clk,
    input  logic          rst,
    mul_fp_pipe_if.slave  bus
);
    localparam int W  = EXP_W + MAN_W + 1;
    localparam int EW = EXP_W + 2;          // signed exponent with headroom for over/underflow
    localparam int PW = 2 * MAN_W + 2;

    localparam logic [EXP_W-1:0]    EXP_ONES = '1;
    localparam logic signed [EW-1:0] BIAS    = EW'((2 ** (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX = {2'b00, EXP_ONES};
    localparam logic [W-1:0]        QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    // All stages move together; the pipe only stalls when the output is held.
    logic advance;
    logic out_valid_reg;
    logic [W-1:0] out_reg;
    logic [3:0]   flags_reg;

    assign advance       = !out_valid_reg || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid_reg;
    assign bus.out       = out_reg;
    assign bus.flags     = flags_reg;

    // ---------------- stage 1: unpack and classify ----------------
    logic [W-1:0]     op      [2];
    logic [EXP_W-1:0] op_exp  [2];
    logic [MAN_W:0]   op_man  [2];
    logic [1:0]       op_sign;
    logic [1:0]       op_zero;
    logic [1:0]       op_inf;
    logic [1:0]       op_nan;

    assign op[0] = bus.a;
    assign op[1] = bus.b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
            assign op_sign[gi] = op[gi][W-1];
            assign op_exp[gi]  = op[gi][W-2 -: EXP_W];
            assign op_man[gi]  = {1'b1, op[gi][MAN_W-1:0]};
            // Denormals have exp = 0 and are treated as zero.
            assign op_zero[gi] = (op_exp[gi] == '0);
            assign op_inf[gi]  = (op_exp[gi] == EXP_ONES) && (op[gi][MAN_W-1:0] == '0);
            assign op_nan[gi]  = (op_exp[gi] == EXP_ONES) && (op[gi][MAN_W-1:0] != '0);
        end
    endgenerate

    logic signed [EW-1:0] esum_next;
    logic                 zero_inf_next;

    assign esum_next     = $signed({2'b00, op_exp[0]}) + $signed({2'b00, op_exp[1]}) - BIAS;
    assign zero_inf_next = (|op_zero) && (|op_inf);

    logic                 s1_valid_reg, s1_sign_reg, s1_nan_reg, s1_invalid_reg;
    logic                 s1_inf_reg, s1_zero_reg;
    logic signed [EW-1:0] s1_esum_reg;
    logic [MAN_W:0]       s1_ma_reg, s1_mb_reg;

    // ---------------- stage 2: mantissa product ----------------
    logic                 s2_valid_reg, s2_sign_reg, s2_nan_reg, s2_invalid_reg;
    logic                 s2_inf_reg, s2_zero_reg;
    logic signed [EW-1:0] s2_esum_reg;
    logic [PW-1:0]        s2_prod_reg;

    // ---------------- stage 3: normalise, round, pack ----------------
    logic                 norm_shift;
    logic [PW-2:0]        norm;
    logic [MAN_W-1:0]     frac;
    logic [MAN_W-1:0]     frac_r;
    logic                 guard, sticky, carry;
    logic signed [EW-1:0] exp_f;
    logic                 ovf, unf;
    logic [W-1:0]         res_next;
    logic [3:0]           flags_next;

    always_comb begin
        norm_shift = s2_prod_reg[PW-1];
        norm       = norm_shift ? s2_prod_reg[PW-2:0] : {s2_prod_reg[PW-3:0], 1'b0};
        frac       = norm[PW-2 -: MAN_W];
        guard      = norm[MAN_W];
        sticky     = |norm[MAN_W-1:0];
`ifdef MUL_FP_ROUND_EN
        // Nearest-even: round up above half, or at exactly half when the LSB is odd.
        {carry, frac_r} = {1'b0, frac}
                        + {{MAN_W{1'b0}}, guard & (sticky | frac[0])};
`else
        carry  = 1'b0;
        frac_r = frac;
`endif
        exp_f = s2_esum_reg
              + $signed({{(EW-1){1'b0}}, norm_shift})
              + $signed({{(EW-1){1'b0}}, carry});
        ovf = !exp_f[EW-1] && (exp_f >= EXP_MAX);
        unf = exp_f[EW-1] || (exp_f == '0);

        res_next   = '0;
        flags_next = '0;
        if (s2_valid_reg) begin
            if (s2_nan_reg) begin
                res_next      = QNAN;
                flags_next[3] = s2_invalid_reg;
            end else if (s2_inf_reg) begin
                res_next = {s2_sign_reg, EXP_ONES, {MAN_W{1'b0}}};
            end else if (s2_zero_reg) begin
                res_next = {s2_sign_reg, {(W-1){1'b0}}};
            end else if (ovf) begin
                res_next   = {s2_sign_reg, EXP_ONES, {MAN_W{1'b0}}};
                flags_next = 4'b0101;
            end else if (unf) begin
                res_next   = {s2_sign_reg, {(W-1){1'b0}}};
                flags_next = 4'b0011;
            end else begin
                res_next      = {s2_sign_reg, exp_f[EXP_W-1:0], frac_r};
                flags_next[0] = guard | sticky;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg   <= 1'b0;
            s1_sign_reg    <= 1'b0;
            s1_nan_reg     <= 1'b0;
            s1_invalid_reg <= 1'b0;
            s1_inf_reg     <= 1'b0;
            s1_zero_reg    <= 1'b0;
            s1_esum_reg    <= '0;
            s1_ma_reg      <= '0;
            s1_mb_reg      <= '0;
            s2_valid_reg   <= 1'b0;
            s2_sign_reg    <= 1'b0;
            s2_nan_reg     <= 1'b0;
            s2_invalid_reg <= 1'b0;
            s2_inf_reg     <= 1'b0;
            s2_zero_reg    <= 1'b0;
            s2_esum_reg    <= '0;
            s2_prod_reg    <= '0;
            out_valid_reg  <= 1'b0;
            out_reg        <= '0;
            flags_reg      <= '0;
        end else if (advance) begin
            s1_valid_reg   <= bus.in_valid;
            s1_sign_reg    <= op_sign[0] ^ op_sign[1];
            s1_nan_reg     <= (|op_nan) || zero_inf_next;
            s1_invalid_reg <= zero_inf_next;
            s1_inf_reg     <= |op_inf;
            s1_zero_reg    <= |op_zero;
            s1_esum_reg    <= esum_next;
            s1_ma_reg      <= op_man[0];
            s1_mb_reg      <= op_man[1];

            s2_valid_reg   <= s1_valid_reg;
            s2_sign_reg    <= s1_sign_reg;
            s2_nan_reg     <= s1_nan_reg;
            s2_invalid_reg <= s1_invalid_reg;
            s2_inf_reg     <= s1_inf_reg;
            s2_zero_reg    <= s1_zero_reg;
            s2_esum_reg    <= s1_esum_reg;
            s2_prod_reg    <= PW'(s1_ma_reg) * PW'(s1_mb_reg);

            out_valid_reg  <= s2_valid_reg;
            out_reg        <= res_next;
            flags_reg      <= flags_next;
        end
    end
endmodule

// File: doc/mul_fp_pipe.md
Name: mul_fp_pipe

Overview:
Parametrised, pipelined IEEE-754-style floating-point multiplier and the next generation of the single-precision combinational multiplier.
- Generic exponent and mantissa widths, 3-stage pipeline with valid/ready handshake.
- Special-value handling (zero, Inf, NaN), round-to-nearest-even, exception flags.
- Sits in the Floating Point Module between operand issue and writeback.

Parameters:
EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1
MAN_W, 23, stored mantissa (fraction) width; hidden bit implied
W, EXP_W+MAN_W+1, total operand width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block accepts operands this cycle
a  in  W  operand A {sign, exp, man}
b  in  W  operand B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out  out  W  product
flags  out  4  {invalid, overflow, underflow, inexact}, aligned with out

Behaviour:
- Reset: clk is single clock; rst asynchronous, active-high. All stage valid bits are 0, out = 0, flags = 0, out_valid = 0. in_ready = 1 after reset release.
- Handshake:
  - advance = !out_valid || out_ready. All three stages shift together when advance = 1 and hold when it is 0.
  - in_ready = advance, combinational.
  - A transfer occurs when in_valid && in_ready. Bubbles propagate as valid = 0.
  - No skid buffer is required.
- Latency: 3 cycles from accepted input to out_valid, with no backpressure. Throughput is 1 per cycle. Results leave in input order.
- out/flags are held stable while out_valid && !out_ready.
- Stage 1 (unpack):
  - so = sa ^ sb.
  - Classify each operand. exp = 0 is zero: denormals are flushed to zero, with no flag. exp = all-ones with man = 0 is Inf. exp = all-ones with man != 0 is NaN.
  - esum = ea + eb - bias, computed signed at EXP_W+2 bits.
- Stage 2: mantissa product {1,ma} * {1,mb}, width 2*MAN_W+2.
- Stage 3 (normalise, round, pack):
  - If product MSB = 1: shift right 1 and esum + 1.
  - Guard/sticky bits are taken from the discarded bits. Round to nearest even.
  - If rounding carries out of the mantissa, renormalise and esum + 1.
  - inexact = 1 when any discarded bit is nonzero.
- Result priority (first match wins):
  1. Either operand NaN -> canonical NaN: sign 0, exp all-ones, man MSB = 1, others 0 (0x7FC00000 for defaults). invalid = 0 unless rule 2 also applies.
  2. Zero × Inf -> canonical NaN, invalid = 1.
  3. Either Inf -> {so, all-ones, 0}.
  4. Either zero -> {so, 0, 0} (signed zero).
  5. Final biased exp >= all-ones -> {so, all-ones, 0}, overflow = 1, inexact = 1.
  6. Final biased exp <= 0 -> {so, 0, 0}, underflow = 1, inexact = 1.
  7. Otherwise normal packed result.
- flags are 0 for exact normal results. flags are cleared when out_valid = 0.
- rst asserted mid-operation clears all in-flight results immediately. No partial result appears after rst release.

Optional Feature:
MUL_FP_ROUND_EN.
- Defined: round-to-nearest-even as specified above.
- Undefined: truncation toward zero. The mantissa carry/renormalise path is removed. inexact is still reported. Overflow/underflow rules are unchanged.

Test Plan:
1. a=0x40000000 (2.0), b=0x40400000 (3.0), out_ready=1 -> out=0x40C00000, flags=0, out_valid exactly 3 cycles after acceptance.
2. a=0x3FC00000, b=0x3F800001 (exact tie) -> with MUL_FP_ROUND_EN: 0x3FC00002, inexact=1; without it: 0x3FC00001, inexact=1.
3. Specials:
   - a=0x00000000, b=0x7F800000 -> 0x7FC00000, invalid=1.
   - a=0xFF800000, b=0x40000000 -> 0xFF800000, flags=0.
   - a=0x80000000, b=0x3F800000 -> 0x80000000.
4. Range:
   - a=b=0x7F000000 -> 0x7F800000, overflow=1, inexact=1.
   - a=b=0x00800000 -> 0x00000000, underflow=1, inexact=1.
5. Backpressure: 6 back-to-back valid inputs with out_ready held 0 for cycles 2-7 -> in_ready drops, out holds steady, all 6 results emerge in order with none lost or duplicated.
6. Reset: assert rst 2 cycles after 3 inputs are accepted -> out_valid=0 and out=0 immediately. After release, the first new input appears 3 cycles after acceptance and no stale result is output.
